// File: rtl/aidc_lite_decomp_zrle_param.sv
// Zero-mask block decompressor: an MSB-first code stream is unpacked into fixed-width lines.
// Each line is addressed within its packet, and the outputs read zero when idle so sibling units can be ORed.
module aidc_lite_decomp_zrle_param #(
    parameter int WORD_W   = 16,
    parameter int WORDS    = 4,
    parameter int BLOCKS   = 16,
    parameter int IN_W     = 32,
    parameter int HDR_BITS = 2,
    parameter int BUF_W    = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic                        sop_i,
    input  logic                        eop_i,
    input  logic [IN_W-1:0]             data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [$clog2(BLOCKS)-1:0]   addr_o,
    output logic [WORDS*WORD_W-1:0]     data_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int ADDR_W = $clog2(BLOCKS);
    localparam int CNT_W  = $clog2(BLOCKS + 1);
    localparam int SZ_W   = $clog2(BUF_W + 1);
    localparam int LINE_W = WORDS * WORD_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [SZ_W-1:0]     size_q, size_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   data_q, data_d;
    logic                err_q, err_d;

    logic [WORDS-1:0]    mask;
    logic [SZ_W-1:0]     blk_len;
    logic [LINE_W-1:0]   line_dec;
    logic [BUF_W-1:0]    walk;
    logic [BUF_W-1:0]    consumed;
    logic [SZ_W-1:0]     rem;
    logic                accept, sop_acc, out_hs, last_hs, fire;

    // The buffer is MSB-aligned: the next unread code bit is always buf_q[BUF_W-1].
    always_comb begin
        mask     = buf_q[BUF_W-1 -: WORDS];
        blk_len  = SZ_W'(WORDS);
        line_dec = '0;
        walk     = buf_q << WORDS;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                line_dec[i*WORD_W +: WORD_W] = walk[BUF_W-1 -: WORD_W];
                walk    = walk << WORD_W;
                blk_len = blk_len + SZ_W'(WORD_W);
            end
        end
    end

    assign ready_o = (size_q <= SZ_W'(BUF_W - IN_W));
    assign accept  = valid_i && ready_o;
    assign sop_acc = accept && sop_i;
    assign out_hs  = valid_q && ready_i;
    assign last_hs = out_hs && (addr_q == ADDR_W'(BLOCKS - 1));
    assign fire    = (state_q == RUN) && (cnt_q < CNT_W'(BLOCKS)) &&
                     (size_q >= SZ_W'(WORDS)) && (size_q >= blk_len) &&
                     (!valid_q || ready_i) && !sop_acc;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        size_d   = size_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        err_d    = err_q;
        consumed = fire ? (buf_q << blk_len) : buf_q;
        rem      = fire ? (size_q - blk_len) : size_q;

        if (out_hs) begin
            valid_d = 1'b0;
        end
        if (fire) begin
            valid_d = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            data_d  = line_dec;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        buf_d  = consumed;
        size_d = rem;

        // A new packet always wins: it aborts whatever is in flight, including a held line.
        if (sop_acc) begin
            if (state_q == RUN) begin
                err_d = 1'b1;
            end
            buf_d   = {data_i[IN_W-HDR_BITS-1:0], {(BUF_W-IN_W+HDR_BITS){1'b0}}};
            size_d  = SZ_W'(IN_W - HDR_BITS);
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (last_hs) begin
            buf_d   = '0;
            size_d  = '0;
            state_d = IDLE;
        end else if (accept) begin
            if (state_q == IDLE) begin
                err_d = 1'b1;
            end else begin
                buf_d  = consumed | ({data_i, {(BUF_W-IN_W){1'b0}}} >> rem);
                size_d = rem + SZ_W'(IN_W);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = valid_q ? addr_q : '0;
    assign data_o  = valid_q ? data_q : '0;
    assign done_o  = (state_q == IDLE);
    assign err_o   = err_q;

endmodule

// File: tb/tb_aidc_lite_decomp_zrle_param.sv
// Directed bench for the zero-mask decompressor; expected lines are hand-decoded from the code streams below.
module tb_aidc_lite_decomp_zrle_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic        sop_i;
    logic        eop_i;
    logic [31:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  addr_o;
    logic [63:0] data_o;
    logic        done_o;
    logic        err_o;

    int compared   = 0;
    int mismatched = 0;

    logic [95:0] stream3;

    aidc_lite_decomp_zrle_param dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .sop_i   (sop_i),
        .eop_i   (eop_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .addr_o  (addr_o),
        .data_o  (data_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic s, input logic [31:0] d);
        valid_i = v;
        sop_i   = s;
        eop_i   = 1'b0;
        data_i  = d;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        waitCycle();
    endtask

    task automatic checkLine(input string tag, input logic [3:0] a, input logic [63:0] d);
        checkOutput({tag, "_valid"}, 64'(valid_o), 64'd1);
        checkOutput({tag, "_addr"}, 64'(addr_o), 64'(a));
        checkOutput({tag, "_data"}, data_o, d);
    endtask

    initial begin
        rst = 1'b1;
        ready_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #12;
        rst = 1'b0;
        waitCycle();

        $display("[TB] reset values");
        checkOutput("rst_valid", 64'(valid_o), 64'd0);
        checkOutput("rst_addr", 64'(addr_o), 64'd0);
        checkOutput("rst_data", data_o, 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd1);
        checkOutput("rst_err", 64'(err_o), 64'd0);
        checkOutput("rst_ready", 64'(ready_o), 64'd1);

        $display("[TB] all-zero sop beat gives seven empty lines");
        applyStimulus(1'b1, 1'b1, 32'h0000_0000);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("z_valid0", 64'(valid_o), 64'd0);
        checkOutput("z_done0", 64'(done_o), 64'd0);
        for (int k = 0; k < 7; k++) begin
            waitCycle();
            checkLine("z_line", 4'(k), 64'h0);
        end
        waitCycle();
        checkOutput("z_tail_valid", 64'(valid_o), 64'd0);
        checkOutput("z_tail_addr", 64'(addr_o), 64'd0);

        $display("[TB] single-word block then zero blocks");
        doReset();
        applyStimulus(1'b1, 1'b1, 32'h22AF_3400);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        waitCycle();
        checkLine("w_line0", 4'd0, 64'hABCD_0000_0000_0000);
        waitCycle();
        checkLine("w_line1", 4'd1, 64'h0);
        waitCycle();
        checkLine("w_line2", 4'd2, 64'h0);
        waitCycle();
        checkOutput("w_tail_valid", 64'(valid_o), 64'd0);
        checkOutput("w_tail_data", data_o, 64'd0);

        $display("[TB] full block spanning three beats");
        doReset();
        stream3 = {2'b00, 4'hF, 64'h1111_2222_3333_4444, 26'd0};
        applyStimulus(1'b1, 1'b1, stream3[95:64]);
        waitCycle();
        applyStimulus(1'b1, 1'b0, stream3[63:32]);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        waitCycle();
        waitCycle();
        checkOutput("f_wait_valid", 64'(valid_o), 64'd0);
        applyStimulus(1'b1, 1'b0, stream3[31:0]);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("f_latency_valid", 64'(valid_o), 64'd0);
        waitCycle();
        checkLine("f_line0", 4'd0, 64'h1111_2222_3333_4444);
        waitCycle();
        checkLine("f_line1", 4'd1, 64'h0);
        checkOutput("f_err", 64'(err_o), 64'd0);

        $display("[TB] sink backpressure then drain to end of packet");
        doReset();
        ready_i = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h0);
        waitCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitCycle();
        checkLine("bp_first", 4'd0, 64'h0);
        waitCycle();
        waitCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("bp_ready_low", 64'(ready_o), 64'd0);
        waitCycle();
        waitCycle();
        waitCycle();
        checkLine("bp_held", 4'd0, 64'h0);
        checkOutput("bp_ready_still_low", 64'(ready_o), 64'd0);
        ready_i = 1'b1;
        for (int k = 1; k < 16; k++) begin
            waitCycle();
            checkLine("bp_drain", 4'(k), 64'h0);
        end
        checkOutput("bp_not_done_yet", 64'(done_o), 64'd0);
        waitCycle();
        checkOutput("pk_done", 64'(done_o), 64'd1);
        checkOutput("pk_valid", 64'(valid_o), 64'd0);
        checkOutput("pk_ready", 64'(ready_o), 64'd1);
        checkOutput("pk_err_clean", 64'(err_o), 64'd0);

        $display("[TB] stray beat after packet end");
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("stray_err", 64'(err_o), 64'd1);
        waitCycle();
        waitCycle();
        checkOutput("stray_valid", 64'(valid_o), 64'd0);
        checkOutput("stray_done", 64'(done_o), 64'd1);

        $display("[TB] sop mid-packet and async reset");
        doReset();
        checkOutput("re_err_cleared", 64'(err_o), 64'd0);
        applyStimulus(1'b1, 1'b1, 32'h0);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            waitCycle();
            checkLine("ab_line", 4'(k), 64'h0);
        end
        applyStimulus(1'b1, 1'b1, 32'h22AF_3400);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("ab_err", 64'(err_o), 64'd1);
        checkOutput("ab_valid_dropped", 64'(valid_o), 64'd0);
        checkOutput("ab_done", 64'(done_o), 64'd0);
        waitCycle();
        checkLine("ab_restart", 4'd0, 64'hABCD_0000_0000_0000);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_valid", 64'(valid_o), 64'd0);
        checkOutput("ar_addr", 64'(addr_o), 64'd0);
        checkOutput("ar_data", data_o, 64'd0);
        checkOutput("ar_done", 64'(done_o), 64'd1);
        checkOutput("ar_err", 64'(err_o), 64'd0);
        checkOutput("ar_ready", 64'(ready_o), 64'd1);
        waitCycle();
        rst = 1'b0;
        waitCycle();
        waitCycle();
        checkOutput("ar_idle_valid", 64'(valid_o), 64'd0);
        checkOutput("ar_idle_done", 64'(done_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
